// File: rtl/avalon_pio_out_pkg.sv
// Shared register-map constants and sizing helper for the avalon_pio_out output port.
package avalon_pio_out_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_BLINK    = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    // Bits needed to count 0..blinkDiv-1, never less than one.
    function automatic int blinkCntWidth(input int blinkDiv);
        int w;
        w = $clog2(blinkDiv);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pio_blink_timer.sv
// Free-running blink half-period divider; phase toggles each time the counter wraps.
module pio_blink_timer
    import avalon_pio_out_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic phase
);

    localparam int              CW   = blinkCntWidth(BLINK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] r_count;
    logic          r_phase;

    // A clear on the wrap cycle wins, so software restarts the blink from a known phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_phase <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_phase <= 1'b0;
        end else if (r_count == LAST) begin
            r_count <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/avalon_pio_out.sv
// Avalon-MM output port with DATA, atomic OUTSET/OUTCLEAR and optional per-bit blink.
// Blink register and timer are built only when AVALON_PIO_OUT_BLINK_EN is defined.
module avalon_pio_out
    import avalon_pio_out_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          BLINK_DIV   = 25_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             w_write;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_blink;
    logic             w_phase;
    logic [31:0]      w_readValue;
    logic             w_unusedWdata;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_out;
    logic [31:0]      r_readdata;

    assign w_write       = chipselect & ~write_n;
    assign w_wdata       = writedata[WIDTH-1:0];
    assign w_unusedWdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE[WIDTH-1:0];
        end else if (w_write) begin
            case (address)
                ADDR_DATA:     r_data <= w_wdata;
                ADDR_OUTSET:   r_data <= r_data | w_wdata;
                ADDR_OUTCLEAR: r_data <= r_data & ~w_wdata;
                default:       ;
            endcase
        end
    end

`ifdef AVALON_PIO_OUT_BLINK_EN
    logic [WIDTH-1:0] r_blink;
    logic             w_blinkWrite;

    assign w_blinkWrite = w_write && (address == ADDR_BLINK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink <= '0;
        end else if (w_blinkWrite) begin
            r_blink <= w_wdata;
        end
    end

    pio_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinkTimer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_blinkWrite),
        .phase   (w_phase)
    );

    assign w_blink = r_blink;
`else
    assign w_blink = '0;
    assign w_phase = 1'b0;
`endif

    // DATA reads return the stored value, never the blinked pin value.
    always_comb begin
        w_readValue = '0;
        case (address)
            ADDR_DATA:  w_readValue[WIDTH-1:0] = r_data;
            ADDR_BLINK: w_readValue[WIDTH-1:0] = w_blink;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_out      <= RESET_VALUE[WIDTH-1:0];
        end else begin
            r_readdata <= w_readValue;
            r_out      <= r_data ^ (w_blink & {WIDTH{w_phase}});
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule
